// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 multiplier datapath.
// Holds the per-format field widths and exponent bias, the canonical quiet-NaN
// and infinity bit patterns, and the controller state encoding.
// The pattern functions return 64-bit values; binary32 users take the low 32 bits.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int fmt_exp_w(input bit is_double);
    return is_double ? 11 : 8;
  endfunction

  function automatic int fmt_frac_w(input bit is_double);
    return is_double ? 52 : 23;
  endfunction

  function automatic int fmt_bias(input bit is_double);
    return is_double ? 1023 : 127;
  endfunction

  // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB set.
  function automatic logic [63:0] fmt_qnan(input bit is_double);
    return is_double ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
  endfunction

  // Positive infinity; callers replace the sign bit.
  function automatic logic [63:0] fmt_inf(input bit is_double);
    return is_double ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
  endfunction

endpackage

// File: rtl/mant_shift_add_mul.sv
// Iterative unsigned mantissa multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start_i      load operands and clear the accumulator (one-cycle pulse)
//   a_i, b_i     MW-bit multiplicand / multiplier
//   done_o       high during the cycle that consumes the last multiplier bit;
//                product_o holds the full product from the following cycle
//   product_o    2*MW-bit product accumulator
module mant_shift_add_mul #(
  parameter int MW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [MW-1:0]   a_i,
  input  logic [MW-1:0]   b_i,
  output logic            done_o,
  output logic [2*MW-1:0] product_o
);

  localparam int CW = $clog2(MW);
  localparam logic [CW-1:0] LAST = CW'(MW - 1);

  logic [2*MW-1:0] acc_q;
  logic [2*MW-1:0] mcand_q;
  logic [MW-1:0]   mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;

  // The multiplicand shifts left while the multiplier shifts right, so each
  // step only needs to inspect mplier_q[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{MW{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_q;

endmodule

// File: rtl/fp_mult_core.sv
// Sequential IEEE-754 multiplier (binary32 or binary64) with flush-to-zero
// inputs, round-to-nearest-even and flush-to-zero on underflow.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready only in IDLE
//   op1, op2             operands
//   opcode               0 = NOP (result 0), 1 = multiply
//   err_in               upstream analyzer error, forces qNaN + error
//   out_valid/out_ready  result handshake; result held until accepted
//   result               product
//   error                NaN operand, 0*inf or err_in
//   overflow             finite product too large, result = signed inf
//   underflow            product below normal range, result = signed zero
//
// state | meaning
// IDLE  | waiting for an operand set; classifies it on acceptance
// MULT  | shift-add mantissa multiply in progress
// ROUND | normalise, round to nearest-even, range check, pack
// DONE  | result presented until out_ready
module fp_mult_core
  import fp_pkg::*;
#(
  parameter bit IS_DOUBLE = 1'b0,
  parameter int WIDTH     = IS_DOUBLE ? 64 : 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             opcode,
  input  logic             err_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             overflow,
  output logic             underflow
);

  localparam int EXP_W  = fmt_exp_w(IS_DOUBLE);
  localparam int FRAC_W = fmt_frac_w(IS_DOUBLE);
  localparam int BIAS   = fmt_bias(IS_DOUBLE);
  localparam int MW     = FRAC_W + 1;
  localparam int PW     = 2 * MW;
  // Two extra bits hold the exponent sum range and its sign.
  localparam int EW     = EXP_W + 2;

  localparam logic [63:0]          QNAN64   = fmt_qnan(IS_DOUBLE);
  localparam logic [63:0]          INF64    = fmt_inf(IS_DOUBLE);
  localparam logic [WIDTH-1:0]     QNAN     = QNAN64[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     INF_MAG  = INF64[WIDTH-1:0];
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] E_MAX    = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] E_ZERO   = '0;

  state_e                 state_q;
  logic [WIDTH-1:0]       result_q;
  logic                   error_q;
  logic                   overflow_q;
  logic                   underflow_q;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;

  // Operand fields and classification (valid only while in IDLE).
  logic                   s1, s2, s_in;
  logic [EXP_W-1:0]       e1, e2;
  logic [FRAC_W-1:0]      f1, f2;
  logic                   nan1, nan2, inf1, inf2, zero1, zero2;
  logic                   invalid_in, normal_in, mul_start;
  logic signed [EW-1:0]   exp_sum;

  assign s1 = op1[WIDTH-1];
  assign s2 = op2[WIDTH-1];
  assign e1 = op1[WIDTH-2 -: EXP_W];
  assign e2 = op2[WIDTH-2 -: EXP_W];
  assign f1 = op1[FRAC_W-1:0];
  assign f2 = op2[FRAC_W-1:0];

  assign s_in  = s1 ^ s2;
  assign nan1  = (e1 == EXP_ONES) && (f1 != '0);
  assign nan2  = (e2 == EXP_ONES) && (f2 != '0);
  assign inf1  = (e1 == EXP_ONES) && (f1 == '0);
  assign inf2  = (e2 == EXP_ONES) && (f2 == '0);
  // Denormals count as zero: inputs are flushed.
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);

  assign invalid_in = nan1 | nan2 | (inf1 & zero2) | (zero1 & inf2);
  assign normal_in  = opcode & ~err_in & ~invalid_in &
                      ~inf1 & ~inf2 & ~zero1 & ~zero2;
  assign mul_start  = (state_q == IDLE) && in_valid && normal_in;
  assign exp_sum    = EW'(e1) + EW'(e2) - EW'(BIAS);

  logic          mul_done;
  logic [PW-1:0] product;

  mant_shift_add_mul #(.MW(MW)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       ({1'b1, f1}),
    .b_i       ({1'b1, f2}),
    .done_o    (mul_done),
    .product_o (product)
  );

  // Rounding datapath, consumed in ROUND once the product is complete.
  // The product of two 1.x mantissas lies in [1,4); normalising left-aligns
  // the leading one at PW-1 so the field positions below are fixed.
  logic                 p_msb;
  logic [PW-1:0]        p_norm;
  logic [FRAC_W-1:0]    frac_t;
  logic                 guard, sticky, rnd_up;
  logic [MW-1:0]        frac_sum;
  logic signed [EW-1:0] exp_rnd;
  logic [WIDTH-1:0]     round_res;
  logic                 round_ovf, round_unf;

  always_comb begin
    p_msb     = product[PW-1];
    p_norm    = p_msb ? product : (product << 1);
    frac_t    = p_norm[PW-2 -: FRAC_W];
    guard     = p_norm[FRAC_W];
    sticky    = |p_norm[FRAC_W-1:0];
    rnd_up    = guard & (sticky | frac_t[0]);
    // A carry out of the fraction leaves it all zeros, i.e. mantissa 1.0
    // one binade up.
    frac_sum  = {1'b0, frac_t} + MW'(rnd_up);
    exp_rnd   = exp_q + EW'(p_msb) + EW'(frac_sum[FRAC_W]);
    round_res = {sign_q, exp_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
    round_ovf = 1'b0;
    round_unf = 1'b0;
    if (exp_rnd >= E_MAX) begin
      round_res = {sign_q, INF_MAG[WIDTH-2:0]};
      round_ovf = 1'b1;
    end else if (exp_rnd <= E_ZERO) begin
      round_res = {sign_q, {(WIDTH-1){1'b0}}};
      round_unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      error_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            result_q    <= '0;
            error_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            sign_q      <= s_in;
            exp_q       <= exp_sum;
            state_q     <= DONE;
            // Order matters: NOP, then any error, then inf, then zero.
            if (!opcode) begin
              result_q <= '0;
            end else if (err_in || invalid_in) begin
              result_q <= QNAN;
              error_q  <= 1'b1;
            end else if (inf1 || inf2) begin
              result_q <= {s_in, INF_MAG[WIDTH-2:0]};
            end else if (zero1 || zero2) begin
              result_q <= {s_in, {(WIDTH-1){1'b0}}};
            end else begin
              state_q <= MULT;
            end
          end
        end
        MULT: begin
          if (mul_done) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q    <= round_res;
          error_q     <= 1'b0;
          overflow_q  <= round_ovf;
          underflow_q <= round_unf;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign error     = error_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_mult_core.sv
// Self-checking bench for fp_mult_core in binary32 mode: directed cases,
// backpressure, reset mid-multiply, then randomized operands against an
// arithmetic reference model.
module tb_fp_mult_core;

  localparam int NORM_LAT = 23 + 3;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic        ovf;
    logic        unf;
    logic        norm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        opcode;
  logic        err_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        error;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fp_mult_core #(.IS_DOUBLE(1'b0), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .opcode    (opcode),
    .err_in    (err_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .error     (error),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic e, input logic o,
                              input logic u, input logic n);
    exp_t r;
    r.res  = res;
    r.err  = e;
    r.ovf  = o;
    r.unf  = u;
    r.norm = n;
    return r;
  endfunction

  // Reference: exact integer product, then rounding decided by comparing the
  // discarded remainder against one half ulp.
  function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   input logic opc, input logic err);
    exp_t            r;
    int              ea, eb, ex, sh;
    logic            s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint unsigned m, q, rem, half;
    r      = '0;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    s      = a[31] ^ b[31];
    nan_a  = (ea == 255) && (a[22:0] != 23'd0);
    nan_b  = (eb == 255) && (b[22:0] != 23'd0);
    inf_a  = (ea == 255) && (a[22:0] == 23'd0);
    inf_b  = (eb == 255) && (b[22:0] == 23'd0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (!opc) return r;
    if (err || nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      r.res = 32'h7FC0_0000;
      r.err = 1'b1;
      return r;
    end
    if (inf_a || inf_b) begin
      r.res = {s, 31'h7F80_0000};
      return r;
    end
    if (zero_a || zero_b) begin
      r.res = {s, 31'h0};
      return r;
    end
    r.norm = 1'b1;
    m    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    sh   = (m >= (64'd1 << 47)) ? 24 : 23;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    ex = ea + eb - 127 + (sh - 23);
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      r.res = {s, 31'h7F80_0000};
      r.ovf = 1'b1;
    end else if (ex <= 0) begin
      r.res = {s, 31'h0};
      r.unf = 1'b1;
    end else begin
      r.res = {s, ex[7:0], q[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    int          sel;
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    sel = int'($urandom_range(0, 15));
    f   = 23'($urandom);
    s   = 1'($urandom);
    if (sel == 0) begin
      e = 8'h00;
    end else if (sel == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = 23'd0;
    end else if (sel < 4) begin
      e = 8'($urandom_range(100, 154));
      f = f & 23'h7FF000;
    end else if (sel < 10) begin
      e = 8'($urandom_range(100, 154));
    end else begin
      e = 8'($urandom_range(1, 254));
    end
    return {s, e, f};
  endfunction

  // Drive an operand set and hold it until accepted (in_ready seen high
  // before a rising edge); returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic opc, input logic err);
    int n;
    n        = 0;
    op1      = a;
    op2      = b;
    opcode   = opc;
    err_in   = err;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed in_ready %0b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency 1 means out_valid is already high just after the accepting edge.
  task automatic collect(input string tag, input exp_t e);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), e.norm ? 64'(NORM_LAT) : 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(e.res));
    chk({tag, "_err"}, 64'(error), 64'(e.err));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
    chk({tag, "_unf"}, 64'(underflow), 64'(e.unf));
    if (out_ready === 1'b1) begin
      @(posedge clk); #1;
      chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
      chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] a, b;
    logic        opc, er;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op1       = '0;
    op2       = '0;
    opcode    = 1'b0;
    err_in    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({error, overflow, underflow}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue(32'h4000_0000, 32'h4040_0000, 1'b1, 1'b0);
    collect("mul_2x3", mk(32'h40C0_0000, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(32'h3F80_0001, 32'h3F80_0001, 1'b1, 1'b0);
    collect("rne_sticky", mk(32'h3F80_0002, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 1'b0);
    collect("mul_1p5sq", mk(32'h4010_0000, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(32'h7FC0_0000, 32'h3F80_0000, 1'b1, 1'b1);
    collect("err_in", mk(32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(32'h0000_0000, 32'hBF80_0000, 1'b1, 1'b0);
    collect("zero_neg", mk(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    collect("nop", mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h7F80_0000, 32'h0000_0000, 1'b1, 1'b0);
    collect("inf_x_zero", mk(32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(32'hFF80_0000, 32'h4000_0000, 1'b1, 1'b0);
    collect("neg_inf", mk(32'hFF80_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h7F00_0000, 32'h7F00_0000, 1'b1, 1'b0);
    collect("overflow", mk(32'h7F80_0000, 1'b0, 1'b1, 1'b0, 1'b1));
    issue(32'h0080_0000, 32'h0080_0000, 1'b1, 1'b0);
    collect("underflow", mk(32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1));

    // Backpressure: result held, new operands ignored until back in IDLE.
    out_ready = 1'b0;
    issue(32'h4000_0000, 32'h4040_0000, 1'b1, 1'b0);
    collect("bp", mk(32'h40C0_0000, 1'b0, 1'b0, 1'b0, 1'b1));
    op1      = 32'h3FC0_0000;
    op2      = 32'h3FC0_0000;
    opcode   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_res", 64'(result), 64'h40C0_0000);
      chk("bp_hold_flags", 64'({error, overflow, underflow}), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 1'b0);
    collect("bp_next", mk(32'h4010_0000, 1'b0, 1'b0, 1'b0, 1'b1));

    // Reset during the tenth MULT cycle aborts with no output.
    issue(32'h4040_0000, 32'h4040_0000, 1'b1, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    issue(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0);
    collect("after_rst", mk(32'h4080_0000, 1'b0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < 300; i++) begin
      a   = rnd_op();
      b   = rnd_op();
      opc = ($urandom_range(0, 19) != 0);
      er  = opc && ($urandom_range(0, 19) == 0);
      e   = ref_mul(a, b, opc, er);
      issue(a, b, opc, er);
      collect("rnd", e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_core.md
Name: fp_mult_core

Overview:
Sequential IEEE-754 multiplier datapath, directly downstream of the operand/opcode error analyzer in the real-multiplier unit. It accepts two operands, the opcode and the analyzer's error flag through a valid/ready handshake. It multiplies mantissas iteratively (shift-add, one bit per cycle), normalises, rounds to nearest-even and returns a registered result with status flags.

Parameters:
IS_DOUBLE, 0, 0 = binary32, 1 = binary64
WIDTH, IS_DOUBLE==1 ? 64 : 32, operand/result width
(derived, not overridable) EXP_W = 8/11, FRAC_W = 23/52, BIAS = 127/1023

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operands (high only in IDLE)
op1  in  WIDTH  first operand
op2  in  WIDTH  second operand
opcode  in  1  0 = NOP, 1 = multiply
err_in  in  1  error flag from the upstream analyzer for this operand set
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  product
error  out  1  invalid operation (NaN operand or 0*inf)
overflow  out  1  finite result exceeded range, result = signed inf
underflow  out  1  result below normal range, flushed to signed zero

Behaviour:
- Reset: state IDLE; in_ready=1 once reset deasserts, out_valid=0, result=0, error=0, overflow=0, underflow=0. Internal accumulator and counter cleared. Reset mid-operation aborts the operation with no output; IDLE on the next cycle.
- States: IDLE, MULT, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, capture the operands, opcode and err_in, then classify:
  - opcode=0 -> DONE with result=0, all flags 0.
  - err_in=1 -> DONE with result = canonical qNaN (0x7FC00000 / 0x7FF8000000000000), error=1.
  - Either operand inf -> DONE with signed inf (sign = s1^s2).
  - Either operand zero or denormal (flush-to-zero on input) -> DONE with signed zero.
  - Otherwise -> MULT.
- Special cases reach out_valid on the cycle after acceptance (latency 1).
- MULT:
  - Operands are the 1.frac mantissas, FRAC_W+1 bits each.
  - Shift-add: one multiplier bit per cycle, counter 0..FRAC_W, which is FRAC_W+1 cycles.
  - Product register is 2*(FRAC_W+1) bits.
  - Exponent sum e = e1 + e2 - BIAS is computed in EXP_W+2 signed bits on entry.
  - -> ROUND when the counter reaches FRAC_W.
- ROUND (1 cycle):
  - If product MSB=1: shift right 1, e+1.
  - Take FRAC_W bits below the leading one, plus guard bit and sticky (OR of the remaining bits).
  - Round to nearest, ties to even. A carry-out of rounding gives mantissa 1.0 and e+1.
  - Then e >= 2^EXP_W-1 -> signed inf, overflow=1.
  - e <= 0 -> signed zero, underflow=1.
  - Else pack sign, e[EXP_W-1:0] and frac.
  - -> DONE.
- DONE:
  - out_valid=1; result and flags are stable while out_valid=1 and out_ready=0.
  - On out_ready -> IDLE, out_valid=0 on the next cycle.
  - in_ready=0 throughout, so there is no overlap: one operation in flight.
- Normal-path latency from the accept edge to out_valid = FRAC_W+3 cycles (26 for binary32, 55 for binary64).
- Flags are mutually exclusive. error has priority over all classifications.

Decomposition:
- Shared package fp_pkg holds:
  - width/bias constants per format (EXP_W, FRAC_W, BIAS)
  - QNAN and INF bit patterns as functions of IS_DOUBLE
  - state enum {IDLE, MULT, ROUND, DONE}
- One sub-module, mant_shift_add_mul: start, operands, done, product; it owns the counter and accumulator.
- Classification, rounding and packing stay in fp_mult_core.

Test Plan:
- binary32 multiply, out_ready=1: 0x40000000 * 0x40400000 -> 0x40C00000, out_valid exactly 26 cycles after accept, flags 0.
- Round-to-nearest-even: 0x3F800001 * 0x3F800001 -> 0x3F800002; 0x3FC00000 * 0x3FC00000 -> 0x40100000.
- Special cases:
  - err_in=1 (op1=0x7FC00000) -> 0x7FC00000, error=1, latency 1.
  - 0x00000000 * 0xBF800000 -> 0x80000000.
  - opcode=0 -> 0x00000000.
- Range limits:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1.
  - 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, in_valid ignored; accept occurs only after return to IDLE.
- Reset mid-operation: assert rst at cycle 10 of MULT -> next cycle IDLE, out_valid=0, in_ready=1; the following multiply 0x40000000 * 0x40000000 -> 0x40800000, correct.
